// File: rtl/ast_trace_disasm.sv
// Debug-only instruction trace disassembler: decodes issued IR words into
// 12-character ASCII strings and queues them, tagged with PC, in a trace FIFO.
module ast_trace_disasm #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PC_W  = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                      Clock_pin,
    input  logic                      Reset_pin,
    input  logic [15:0]               IR,
    input  logic                      IR_valid,
    input  logic [PC_W-1:0]           PC,
    input  logic                      trace_enable,
    output logic [95:0]               ICis,
    output logic                      trace_valid,
    input  logic                      trace_ready,
    output logic [95:0]               trace_text,
    output logic [PC_W-1:0]           trace_pc,
    output logic [$clog2(DEPTH):0]    trace_count,
    output logic [CNT_W-1:0]          drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [95:0] RST_STR = {"RST", {9{8'h20}}};

    // ASCII uppercase hex digit of a nibble
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'(8'h30 + 8'(n)) : 8'(8'h37 + 8'(n));
    endfunction

    // Mnemonic left-justified in a 5-character field
    function automatic logic [39:0] mnem(input logic [5:0] op);
        case (op)
            6'h02: return "CPY  ";
            6'h03: return "SWAP ";
            6'h05: return "ADD  ";
            6'h06: return "SUB  ";
            6'h07: return "ADDC ";
            6'h08: return "SUBC ";
            6'h0A: return "AND  ";
            6'h0B: return "OR   ";
            6'h0C: return "SRA  ";
            6'h0D: return "SRL  ";
            6'h0E: return "VADD ";
            6'h0F: return "VSUB ";
            6'h10: return "MUL  ";
            6'h11: return "DIV  ";
            6'h12: return "XOR  ";
            6'h13: return "ROTL ";
            6'h14: return "ROTR ";
            6'h15: return "RLZ  ";
            6'h16: return "RLN  ";
            6'h17: return "RRC  ";
            6'h18: return "RRV  ";
            6'h19: return "CALL ";
            6'h1A: return "RET  ";
            default: return "     ";
        endcase
    endfunction

    logic [5:0]  op;
    logic [7:0]  ha, hb, jx, jv;
    logic [95:0] dec;
    logic        unused_ir;

    assign op        = IR[13:8];
    assign ha        = hex_char(IR[7:4]);
    assign hb        = hex_char(IR[3:0]);
    assign unused_ir = ^IR[15:14];

    // Combinational decode of the current IR into its ASCII string
    always_comb begin
        dec = {"NDEF", {8{8'h20}}};
        jx  = "?";
        jv  = "?";
        case (IR[3:0])
            4'b0000: begin jx = "U"; jv = " "; end
            4'b1000: begin jx = "C"; jv = "1"; end
            4'b0100: begin jx = "N"; jv = "1"; end
            4'b0010: begin jx = "V"; jv = "1"; end
            4'b0001: begin jx = "Z"; jv = "1"; end
            4'b0111: begin jx = "C"; jv = "0"; end
            4'b1011: begin jx = "N"; jv = "0"; end
            4'b1101: begin jx = "V"; jv = "0"; end
            4'b1110: begin jx = "Z"; jv = "0"; end
            default: begin jx = "?"; jv = "?"; end
        endcase
        case (op)
            6'h02, 6'h03, 6'h05, 6'h06, 6'h0A, 6'h0B, 6'h0E, 6'h0F,
            6'h10, 6'h11, 6'h12:
                dec = {mnem(op), "R", ha, ", R", hb, ";"};
            6'h07, 6'h08, 6'h0C, 6'h0D, 6'h13, 6'h14, 6'h15, 6'h16,
            6'h17, 6'h18, 6'h19, 6'h1A:
                dec = {mnem(op), "R", ha, ", #", hb, ";"};
            6'h00:   dec = {"LD R", hb, ", MAr", ha, ";"};
            6'h01:   dec = {"ST R", hb, ", MAr", ha, ";"};
            6'h09:   dec = {"NOT  R", ha, "    ;"};
            6'h04:   dec = {"JUMP if ", jx, "=", jv, ";"};
            6'h3F:   dec = {"STALL", {7{8'h20}}};
            default: dec = {"NDEF", {8{8'h20}}};
        endcase
    end

    logic              capture;
    logic              push_vld;
    logic [95:0]       push_text;
    logic [PC_W-1:0]   push_pc;

    assign capture = IR_valid & trace_enable;

    // Stage 1: register decoded string to the live view and the push register
    always_ff @(posedge Clock_pin or posedge Reset_pin) begin
        if (Reset_pin) begin
            ICis      <= RST_STR;
            push_vld  <= 1'b0;
            push_text <= '0;
            push_pc   <= '0;
        end else begin
            push_vld <= capture;
            if (capture) begin
                ICis      <= dec;
                push_text <= dec;
                push_pc   <= PC;
            end
        end
    end

    logic [95:0]     mem_text [DEPTH];
    logic [PC_W-1:0] mem_pc   [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            full, pop, do_push, do_drop;

    assign full        = (trace_count == CW'(DEPTH));
    assign trace_valid = (trace_count != '0);
    assign pop         = trace_valid & trace_ready;
    assign do_push     = push_vld & (~full | pop);
    assign do_drop     = push_vld & full & ~pop;
    assign trace_text  = mem_text[rd_ptr];
    assign trace_pc    = mem_pc[rd_ptr];

    // Stage 2: trace FIFO storage, pointers, occupancy and drop counter
    always_ff @(posedge Clock_pin or posedge Reset_pin) begin
        if (Reset_pin) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_text[i] <= '0;
                mem_pc[i]   <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            trace_count <= '0;
            drop_count  <= '0;
        end else begin
            if (do_push) begin
                mem_text[wr_ptr] <= push_text;
                mem_pc[wr_ptr]   <= push_pc;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, pop})
                2'b10:   trace_count <= trace_count + CW'(1);
                2'b01:   trace_count <= trace_count - CW'(1);
                default: trace_count <= trace_count;
            endcase
            if (do_drop && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ast_trace_disasm.sv
// Self-checking bench for ast_trace_disasm: decode table, directed FIFO
// corner cases and randomized traffic against a queue-based reference model.
module tb_ast_trace_disasm;

    localparam int DEPTH = 8;

    logic        Clock_pin = 1'b0;
    logic        Reset_pin = 1'b0;
    logic [15:0] IR = '0;
    logic        IR_valid = 1'b0;
    logic [15:0] PC = '0;
    logic        trace_enable = 1'b0;
    logic        trace_ready = 1'b0;
    logic [95:0] ICis;
    logic        trace_valid;
    logic [95:0] trace_text;
    logic [15:0] trace_pc;
    logic [3:0]  trace_count;
    logic [15:0] drop_count;

    ast_trace_disasm #(.DEPTH(DEPTH), .PC_W(16), .CNT_W(16)) dut (
        .Clock_pin(Clock_pin), .Reset_pin(Reset_pin), .IR(IR), .IR_valid(IR_valid),
        .PC(PC), .trace_enable(trace_enable), .ICis(ICis), .trace_valid(trace_valid),
        .trace_ready(trace_ready), .trace_text(trace_text), .trace_pc(trace_pc),
        .trace_count(trace_count), .drop_count(drop_count)
    );

    always #5 Clock_pin = ~Clock_pin;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct { logic [95:0] text; logic [15:0] pc; } ent_t;
    typedef struct { logic [15:0] ir; logic [95:0] exp; } vec_t;

    ent_t        q[$];
    logic        pend_v = 1'b0;
    ent_t        pend;
    logic [15:0] m_drop = '0;
    logic [95:0] m_ics;
    string       mn[64];
    int          kind[64];
    vec_t        tbl[16];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic string pad(input string s, input int n);
        string r = s;
        while (r.len() < n) r = {r, " "};
        return r;
    endfunction

    function automatic string hexs(input logic [3:0] n);
        string hx = "0123456789ABCDEF";
        return hx.substr(int'(n), int'(n));
    endfunction

    // Reference decode written from the string rules
    function automatic string model_str(input logic [15:0] ir);
        int    op = int'(ir[13:8]);
        string a = hexs(ir[7:4]);
        string b = hexs(ir[3:0]);
        string s;
        if (kind[op] == 1) s = $sformatf("%sR%s, R%s;", pad(mn[op], 5), a, b);
        else if (kind[op] == 2) s = $sformatf("%sR%s, #%s;", pad(mn[op], 5), a, b);
        else if (op == 0) s = $sformatf("LD R%s, MAr%s;", b, a);
        else if (op == 1) s = $sformatf("ST R%s, MAr%s;", b, a);
        else if (op == 9) s = {pad($sformatf("NOT  R%s", a), 11), ";"};
        else if (op == 4) begin
            string flags = "CNVZ";
            string x = "?";
            string v = "?";
            logic [3:0] code = ir[3:0];
            int ones = $countones(code);
            if (code == 4'b0000) begin x = "U"; v = " "; end
            else if (ones == 1 || ones == 3) begin
                for (int i = 0; i < 4; i++)
                    if (code[3-i] == (ones == 1)) x = flags.substr(i, i);
                v = (ones == 1) ? "1" : "0";
            end
            s = $sformatf("JUMP if %s=%s;", x, v);
        end
        else if (op == 63) s = "STALL";
        else s = "NDEF";
        return pad(s, 12);
    endfunction

    function automatic logic [95:0] to_bits(input string s);
        logic [95:0] r = '0;
        for (int i = 0; i < 12; i++) r[95-8*i -: 8] = s[i];
        return r;
    endfunction

    task automatic model_edge(input logic [15:0] ir, input logic v, input logic [15:0] pc,
                              input logic en, input logic rdy);
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (pend_v) begin
            if (q.size() < DEPTH) q.push_back(pend);
            else if (m_drop != 16'hFFFF) m_drop++;
        end
        pend_v = v && en;
        if (pend_v) begin
            pend.text = to_bits(model_str(ir));
            pend.pc   = pc;
            m_ics     = pend.text;
        end
    endtask

    task automatic check_all();
        chk("valid", trace_valid, q.size() != 0);
        chk("count", trace_count, q.size());
        chk("drop", drop_count, m_drop);
        chk("ICis", ICis, m_ics);
        if (q.size() != 0) begin
            chk("head_text", trace_text, q[0].text);
            chk("head_pc", trace_pc, q[0].pc);
        end
    endtask

    // One clock: drive at negedge, model at posedge, check at next negedge
    task automatic cycle(input logic [15:0] ir, input logic v, input logic [15:0] pc,
                         input logic en, input logic rdy);
        IR = ir; IR_valid = v; PC = pc; trace_enable = en; trace_ready = rdy;
        @(posedge Clock_pin);
        model_edge(ir, v, pc, en, rdy);
        @(negedge Clock_pin);
        check_all();
    endtask

    task automatic do_reset();
        IR_valid = 1'b0; trace_ready = 1'b0;
        Reset_pin = 1'b1;
        #2;
        chk("rst_ICis", ICis, {"RST", {9{8'h20}}});
        chk("rst_valid", trace_valid, 1'b0);
        chk("rst_count", trace_count, 4'd0);
        chk("rst_drop", drop_count, 16'd0);
        chk("rst_text", trace_text, 96'd0);
        chk("rst_pc", trace_pc, 16'd0);
        @(posedge Clock_pin);
        @(negedge Clock_pin);
        Reset_pin = 1'b0;
        q.delete();
        pend_v = 1'b0;
        m_drop = '0;
        m_ics  = {"RST", {9{8'h20}}};
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin mn[i] = ""; kind[i] = 0; end
        mn[2] = "CPY";  mn[3] = "SWAP"; mn[5] = "ADD";  mn[6] = "SUB";
        mn[10] = "AND"; mn[11] = "OR";  mn[14] = "VADD"; mn[15] = "VSUB";
        mn[16] = "MUL"; mn[17] = "DIV"; mn[18] = "XOR";
        foreach (mn[i]) if (mn[i] != "") kind[i] = 1;
        mn[7] = "ADDC"; mn[8] = "SUBC"; mn[12] = "SRA"; mn[13] = "SRL";
        mn[19] = "ROTL"; mn[20] = "ROTR"; mn[21] = "RLZ"; mn[22] = "RLN";
        mn[23] = "RRC"; mn[24] = "RRV"; mn[25] = "CALL"; mn[26] = "RET";
        foreach (mn[i]) if (mn[i] != "" && kind[i] == 0) kind[i] = 2;

        tbl[0]  = '{16'h05A3, "ADD  RA, R3;"};
        tbl[1]  = '{16'h00F1, "LD R1, MArF;"};
        tbl[2]  = '{16'h01F1, "ST R1, MArF;"};
        tbl[3]  = '{16'h09F1, "NOT  RF    ;"};
        tbl[4]  = '{16'h07F1, "ADDC RF, #1;"};
        tbl[5]  = '{16'h04FE, "JUMP if Z=0;"};
        tbl[6]  = '{16'h04F3, "JUMP if ?=?;"};
        tbl[7]  = '{16'h0400, "JUMP if U= ;"};
        tbl[8]  = '{16'h0408, "JUMP if C=1;"};
        tbl[9]  = '{16'h040B, "JUMP if N=0;"};
        tbl[10] = '{16'h3FF1, "STALL       "};
        tbl[11] = '{16'h1BF1, "NDEF        "};
        tbl[12] = '{16'hC2F1, "CPY  RF, R1;"};
        tbl[13] = '{16'h1AF1, "RET  RF, #1;"};
        tbl[14] = '{16'h120B, "XOR  R0, RB;"};
        tbl[15] = '{16'h0C5D, "SRA  R5, #D;"};

        @(negedge Clock_pin);
        do_reset();

        // single capture and two-cycle latency
        cycle(16'h05A3, 1'b1, 16'h0010, 1'b1, 1'b0);
        chk("single_ICis", ICis, "ADD  RA, R3;");
        chk("single_valid_n", trace_valid, 1'b0);
        cycle(16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("single_valid_n1", trace_valid, 1'b1);
        chk("single_pc", trace_pc, 16'h0010);

        // decode table
        foreach (tbl[i]) begin
            cycle(tbl[i].ir, 1'b1, 16'(i), 1'b1, 1'b1);
            chk($sformatf("tbl%0d", i), ICis, tbl[i].exp);
        end

        // opcode sweep with IR[7:0]=F1
        for (int op = 0; op < 64; op++)
            cycle({2'b00, 6'(op), 8'hF1}, 1'b1, 16'(16'h0200 + op), 1'b1, 1'b1);

        // overflow: 11 captures, no consumer
        do_reset();
        for (int i = 0; i < 11; i++)
            cycle(16'h0500 + 16'(i), 1'b1, 16'(16'h0100 + i), 1'b1, 1'b0);
        cycle(16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("ovf_count", trace_count, 4'd8);
        chk("ovf_drop", drop_count, 16'd3);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain_pc", trace_pc, 16'(16'h0100 + i));
            cycle(16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1);
        end
        chk("ovf_empty", trace_valid, 1'b0);

        // full with simultaneous pop and push
        do_reset();
        for (int i = 0; i < 9; i++)
            cycle(16'h0600 + 16'(i), 1'b1, 16'(16'h0300 + i), 1'b1, 1'b0);
        chk("fullpop_fill", trace_count, 4'd8);
        for (int i = 0; i < 20; i++) begin
            cycle(16'h0A00 + 16'(i), 1'b1, 16'(16'h0400 + i), 1'b1, 1'b1);
            chk("fullpop_count", trace_count, 4'd8);
            chk("fullpop_drop", drop_count, 16'd0);
        end

        // gating: in-flight entry still pushed, nothing new captured
        do_reset();
        cycle(16'h05A3, 1'b1, 16'h0020, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(16'h12FF, 1'b1, 16'h0099, 1'b0, 1'b0);
            chk("gate_ICis", ICis, "ADD  RA, R3;");
            chk("gate_count", trace_count, 4'd1);
        end

        // reset mid-stream with 5 queued
        do_reset();
        for (int i = 0; i < 5; i++)
            cycle(16'h0700 + 16'(i), 1'b1, 16'(16'h0500 + i), 1'b1, 1'b0);
        cycle(16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("mid_count5", trace_count, 4'd5);
        do_reset();
        cycle(16'h09C0, 1'b1, 16'h0055, 1'b1, 1'b0);
        chk("mid_valid_n", trace_valid, 1'b0);
        cycle(16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("mid_valid_n1", trace_valid, 1'b1);
        chk("mid_pc", trace_pc, 16'h0055);
        chk("mid_text", trace_text, "NOT  RC    ;");

        // randomized traffic with varying backpressure
        for (int blk = 0; blk < 15; blk++) begin
            int rp = int'($urandom_range(1, 9));
            for (int i = 0; i < 100; i++)
                cycle(16'($urandom), ($urandom % 4) != 0, 16'($urandom),
                      ($urandom % 8) != 0, int'($urandom % 10) < rp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
